// File: rtl/pid_param.sv
// Heading PID controller: wrapped heading error, saturating integrator and derivative history,
// differential left/right motor speed around a forward speed, plus an at-heading flag.
module pid_param #(
  parameter int unsigned HDNG_W    = 12,
  parameter int unsigned FWD_W     = 11,
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned ERR_W     = 10,
  parameter int unsigned P_COEF    = 3,
  parameter int unsigned D_COEF    = 5,
  parameter int unsigned DIFF_W    = 7,
  parameter int unsigned D_DEPTH   = 2,
  parameter int unsigned INTEG_W   = 16,
  parameter int unsigned I_SHIFT   = 4,
  parameter int unsigned PID_SHIFT = 3,
  parameter int unsigned AT_THRESH = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    moving,
  input  logic [HDNG_W-1:0]       dsrd_hdng,
  input  logic [HDNG_W-1:0]       actl_hdng,
  input  logic                    hdng_vld,
  input  logic [FWD_W-1:0]        frwrd_spd,
  output logic signed [OUT_W-1:0] lft_spd,
  output logic signed [OUT_W-1:0] rght_spd,
  output logic                    at_hdng
);

  localparam int unsigned MaxA = (INTEG_W > ERR_W) ? INTEG_W : ERR_W;
  localparam int unsigned MaxB = (HDNG_W > OUT_W) ? HDNG_W : OUT_W;
  localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxD = (MaxC > FWD_W) ? MaxC : FWD_W;
  localparam int unsigned MaxW = (MaxD > DIFF_W) ? MaxD : DIFF_W;
  // Headroom for a full 32-bit gain times the widest operand plus the three-term sum.
  localparam int unsigned SumW = MaxW + 36;

  localparam logic signed [SumW-1:0] PCoef    = SumW'(P_COEF);
  localparam logic signed [SumW-1:0] DCoef    = SumW'(D_COEF);
  localparam logic signed [SumW-1:0] AtThresh = SumW'(AT_THRESH);

  function automatic logic signed [SumW-1:0] sat(input logic signed [SumW-1:0] v,
                                                 input int unsigned             w);
    logic signed [SumW-1:0] hi, lo;
    hi = (SumW'(1) << (w - 1)) - SumW'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  logic signed [ERR_W-1:0]   err_q;
  logic signed [ERR_W-1:0]   hist_q [D_DEPTH];
  logic signed [INTEG_W-1:0] integ_q;
  logic signed [OUT_W-1:0]   lft_spd_q, rght_spd_q;
  logic                      at_hdng_q;

  logic signed [HDNG_W-1:0]  err_raw;
  logic signed [ERR_W-1:0]   err_sat;
  logic signed [INTEG_W-1:0] integ_d;
  logic signed [SumW-1:0]    err_q_w, p_term, i_term, d_term, pid, fwd_w, err_abs;
  logic signed [OUT_W-1:0]   lft_d, rght_d;
  logic                      at_d;

  always_comb begin
    // Modular subtraction reinterpreted as signed gives the shortest way round the circle.
    err_raw = actl_hdng - dsrd_hdng;
    err_sat = ERR_W'(sat(SumW'(err_raw), ERR_W));
    integ_d = INTEG_W'(sat(SumW'(integ_q) + SumW'(err_sat), INTEG_W));

    err_q_w = SumW'(err_q);
    p_term  = PCoef * err_q_w;
    i_term  = SumW'(integ_q) >>> I_SHIFT;
    d_term  = DCoef * sat(err_q_w - SumW'(hist_q[D_DEPTH-1]), DIFF_W);
    pid     = (p_term + i_term + d_term) >>> PID_SHIFT;

    fwd_w   = SumW'(frwrd_spd);
    lft_d   = OUT_W'(sat(fwd_w + pid, OUT_W));
    rght_d  = OUT_W'(sat(fwd_w - pid, OUT_W));

    err_abs = err_q_w[SumW-1] ? -err_q_w : err_q_w;
    at_d    = err_abs < AtThresh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= '0;
      integ_q    <= '0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      at_hdng_q  <= 1'b0;
      for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      if (hdng_vld) begin
        hist_q[0] <= err_q;
        for (int k = D_DEPTH - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
        err_q <= err_sat;
      end
      // The integrator only runs while moving; standing still discards accumulated error.
      if (!moving)       integ_q <= '0;
      else if (hdng_vld) integ_q <= integ_d;

      lft_spd_q  <= moving ? lft_d  : '0;
      rght_spd_q <= moving ? rght_d : '0;
      at_hdng_q  <= at_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;
  assign at_hdng  = at_hdng_q;

endmodule

// File: doc/pid_param.md
PID_PARAM -- requirements
Module: pid_param

Interface
Parameters
REQ-001 HDNG_W, 12: heading width, unsigned, modulo 2^HDNG_W.
REQ-002 FWD_W, 11: forward-speed width, unsigned.
REQ-003 OUT_W, 12: motor-speed output width, signed.
REQ-004 ERR_W, 10: saturated error width, signed.
REQ-005 P_COEF, 3: proportional gain, unsigned integer.
REQ-006 D_COEF, 5: derivative gain, unsigned integer.
REQ-007 DIFF_W, 7: saturated derivative-difference width, signed.
REQ-008 D_DEPTH, 2: derivative history depth in samples, legal range 1..8.
REQ-009 INTEG_W, 16: integrator width, signed.
REQ-010 I_SHIFT, 4: integrator arithmetic right shift.
REQ-011 PID_SHIFT, 3: arithmetic right shift applied to the PID sum.
REQ-012 AT_THRESH, 30: at-heading magnitude threshold.

Ports
REQ-013 clk  in  1  system clock, rising edge.
REQ-014 rst  in  1  reset, synchronous, active-high.
REQ-015 moving  in  1  enables PID influence and integration.
REQ-016 dsrd_hdng  in  HDNG_W  desired heading.
REQ-017 actl_hdng  in  HDNG_W  measured heading.
REQ-018 hdng_vld  in  1  qualifies a new actl_hdng sample.
REQ-019 frwrd_spd  in  FWD_W  forward speed.
REQ-020 lft_spd  out  OUT_W  signed left motor speed, registered.
REQ-021 rght_spd  out  OUT_W  signed right motor speed, registered.
REQ-022 at_hdng  out  1  registered; high when the heading is within the threshold.

Function
REQ-023 Raw error SHALL be (actl_hdng - dsrd_hdng) mod 2^HDNG_W, interpreted as HDNG_W-bit signed, so the shortest wrapped difference is used.
REQ-024 err_sat SHALL be the raw error saturated to ERR_W signed bits, range [-2^(ERR_W-1), 2^(ERR_W-1)-1].
REQ-025 On a clk edge with hdng_vld=1, the following SHALL update simultaneously:
- hist[0] <= err_q
- hist[k] <= hist[k-1]
- err_q <= err_sat
- integ <= sat_INTEG_W(integ + err_sat), only when moving=1
REQ-026 With hdng_vld=0, err_q, hist and integ SHALL hold their values.
REQ-027 With moving=0, integ SHALL clear to 0 at the next edge; err_q and hist SHALL still update per REQ-025.
REQ-028 The integrator SHALL saturate to [-2^(INTEG_W-1), 2^(INTEG_W-1)-1] and never wrap.
REQ-029 Derivative term SHALL be D = D_COEF * sat_DIFF_W(err_q - hist[D_DEPTH-1]).
REQ-030 Proportional term SHALL be P = P_COEF * err_q; integral term SHALL be I = integ >>> I_SHIFT.
REQ-031 pid = (P + I + D) >>> PID_SHIFT, computed at a width wide enough that no intermediate overflows.
REQ-032 Every clk edge, with moving=1:
- lft_spd <= sat_OUT_W(frwrd_spd + pid)
- rght_spd <= sat_OUT_W(frwrd_spd - pid)
REQ-033 Every clk edge, with moving=0, lft_spd and rght_spd SHALL be set to 0.
REQ-034 Every clk edge, at_hdng <= (|err_q| < AT_THRESH), independent of moving.
REQ-035 Latency: a sample taken at edge N SHALL appear on the outputs after edge N+1.
REQ-036 With hdng_vld held low, the outputs SHALL remain constant while moving and frwrd_spd are unchanged.

Reset
REQ-037 With rst=1 at a clk edge, the following SHALL clear to 0: err_q, all hist entries, integ, lft_spd, rght_spd and at_hdng.
REQ-038 rst SHALL take priority over hdng_vld and moving.
REQ-039 Reset asserted mid-operation SHALL take effect at the next edge with no residual integrator or history state.

Verification (default parameters, frwrd_spd=0x200)
REQ-040 Equal headings: dsrd=actl=0x000, moving=1, hdng_vld=1 -> lft=rght=0x200 and at_hdng=1 after 2 edges.
REQ-041 Step west from reset: dsrd=0x3FF, actl=0x000, one valid sample -> err_q=-512, integ=-512, P=-1536, I=-32, D=-320, pid=-236; next edge lft=276, rght=748.
REQ-042 Wrap-around: dsrd=0xFF0, actl=0x00A -> err_q=+26 and at_hdng=1. With actl=0x010 -> err_q=+32 and at_hdng=0; the error SHALL never be -4064.
REQ-043 Anti-windup: err_sat=-512 held for 70 valid samples -> integ=-32768 from sample 64 onward with no wrap. Then moving=0 -> integ=0 and outputs 0 next edge.
REQ-044 Output saturation: frwrd_spd=0x7FF, pid=-236 -> lft=1811, rght=2047 (clamped).
REQ-045 Freeze and reset: lower hdng_vld for 4 cycles -> outputs unchanged. Then rst=1 for 1 edge -> all outputs and state 0 on that edge.
